// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit port among NREQ byte-stream
// requesters. Each requester has a private FIFO. Arbitration is round-robin
// with line locking: the owner keeps the port until it sends LF (0x0A) or
// leaves its FIFO empty for LOCK_TIMEOUT cycles.
// Build option: define ARB_CRLF_EN to expand every LF into CR LF on the wire.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_full,
    input  logic              tx_full,
    output logic              tx,
    output logic [7:0]        tx_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ovf,
    input  logic              ovf_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 16;
    localparam logic [7:0]  LF_BYTE = 8'h0A;
`ifdef ARB_CRLF_EN
    localparam logic [7:0]  CR_BYTE = 8'h0D;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_LF} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;
`endif

    logic [7:0]      mem    [NREQ][DEPTH];
    logic [PW-1:0]   wr_ptr [NREQ];
    logic [PW-1:0]   rd_ptr [NREQ];
    logic [PW-1:0]   wr_nxt [NREQ];
    logic [PW-1:0]   rd_nxt [NREQ];
    logic [NREQ-1:0] empty;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] full_nxt;
    logic [NREQ-1:0] avail;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   owner_n;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   rr_n;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [CW-1:0]   idle_cnt;
    logic [CW-1:0]   cnt_n;
    logic [CW-1:0]   cnt_inc;
    logic            rel;
    logic            tx_n;
    logic [7:0]      data_n;
    logic [7:0]      head;
    logic [NREQ-1:0] grant_n;

    // Requester index advanced by off with wrap at NREQ.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // A write is stored only when the registered full flag is clear.
    assign push    = req_wr & ~req_full;
    assign head    = mem[owner][rd_ptr[owner][AW-1:0]];
    assign cnt_inc = idle_cnt + CW'(1);

    // FIFO empty flags from current pointers.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
        end
    end

    // Next pointers and next-cycle full (MSB differs, index bits equal).
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_nxt[i]   = wr_ptr[i] + PW'(push[i]);
            rd_nxt[i]   = rd_ptr[i] + PW'(pop[i]);
            full_nxt[i] = (wr_nxt[i][AW] != rd_nxt[i][AW]) &&
                          (wr_nxt[i][AW-1:0] == rd_nxt[i][AW-1:0]);
        end
    end

    // FIFO storage; written bytes need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= req_data[8*i +: 8];
        end
    end

    // FIFO pointers and registered full flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            req_full <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= wr_nxt[i];
                rd_ptr[i] <= rd_nxt[i];
            end
            req_full <= full_nxt;
        end
    end

    // Sticky overflow; a clear wins over a same-cycle overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else if (ovf_clr) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (req_wr & req_full);
        end
    end

    // Round-robin pick: first requester with data (or a write landing now) from rr_ptr upward.
    always_comb begin
        avail    = ~empty | push;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!pick_vld && avail[wrap_inc(rr_ptr, k)]) begin
                pick     = wrap_inc(rr_ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and output logic; grant stays up through the final strobe of a line.
    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        cnt_n   = idle_cnt;
        grant_n = grant;
        tx_n    = 1'b0;
        data_n  = tx_data;
        pop     = '0;
        rel     = 1'b0;
        case (state)
            S_IDLE: begin
                grant_n = '0;
                if (pick_vld) begin
                    state_n = S_SEND;
                    owner_n = pick;
                    grant_n = NREQ'(1) << pick;
                    cnt_n   = '0;
                end
            end
            S_SEND: begin
                if (empty[owner]) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CW'(LOCK_TIMEOUT)) rel = 1'b1;
                end else if (!tx_full) begin
                    tx_n  = 1'b1;
                    cnt_n = '0;
`ifdef ARB_CRLF_EN
                    if (head == LF_BYTE) begin
                        data_n  = CR_BYTE;
                        state_n = S_LF;
                    end else begin
                        data_n     = head;
                        pop[owner] = 1'b1;
                    end
`else
                    data_n     = head;
                    pop[owner] = 1'b1;
                    rel        = (head == LF_BYTE);
`endif
                end
            end
`ifdef ARB_CRLF_EN
            S_LF: begin
                if (!tx_full) begin
                    tx_n       = 1'b1;
                    data_n     = LF_BYTE;
                    pop[owner] = 1'b1;
                    rel        = 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
        if (rel) begin
            state_n = S_IDLE;
            rr_n    = wrap_inc(owner, 1);
            cnt_n   = '0;
            grant_n = tx_n ? grant : '0;
        end
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
            grant    <= '0;
            tx       <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_n;
            idle_cnt <= cnt_n;
            grant    <= grant_n;
            tx       <= tx_n;
            tx_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (NREQ=2, DEPTH=4).
// Expected UART bytes and owning grant are queued as stimulus is driven and
// compared whenever the DUT strobes tx. Honours ARB_CRLF_EN like the design.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LT    = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_wr;
    logic [15:0] req_data;
    logic [1:0]  req_full;
    logic        tx_full;
    logic        tx;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic [1:0]  ovf;
    logic        ovf_clr;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] sb [$];
    logic [15:0] mon_e;
    logic        prev_full  = 1'b0;
    logic [1:0]  prev_grant = 2'b00;
    int          nb;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .DEPTH(DEPTH),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_wr(req_wr),
        .req_data(req_data),
        .req_full(req_full),
        .tx_full(tx_full),
        .tx(tx),
        .tx_data(tx_data),
        .grant(grant),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic [1:0] g);
`ifdef ARB_CRLF_EN
        if (b == 8'h0A) sb.push_back({6'b0, g, 8'h0D});
`endif
        sb.push_back({6'b0, g, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] m, input logic [7:0] d0, input logic [7:0] d1);
        req_wr   = m;
        req_data = {d1, d0};
        tick();
        req_wr   = 2'b00;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        check(tag, 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // tx_full as seen by the DUT at each active edge.
    always @(posedge clk) prev_full <= tx_full;

    // Output monitor: each strobe must match the scoreboard head and its owner.
    always @(negedge clk) begin
        if (rst) begin
            if (grant != prev_grant) check("tx_on_grant_change", 32'(tx), 0);
            if (tx) begin
                check("tx_while_full", 32'(prev_full), 0);
                if (sb.size() == 0) begin
                    check("tx_unexpected", 32'(tx), 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_e[7:0]));
                    check("tx_grant", 32'(grant), 32'(mon_e[9:8]));
                end
            end
        end
        prev_grant = grant;
    end

    initial begin
        rst = 1'b0; req_wr = '0; req_data = '0; tx_full = 1'b0; ovf_clr = 1'b0;
        do_reset();
        check("rst_tx", 32'(tx), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_req_full", 32'(req_full), 0);
        check("rst_ovf", 32'(ovf), 0);

        // Single byte: grant at N+1, strobe at N+2, release after LT idle cycles.
        expect_byte(8'h41, 2'b01);
        wr(2'b01, 8'h41, 8'h00);
        check("t1_grant_n1", 32'(grant), 1);
        check("t1_tx_n1", 32'(tx), 0);
        tick();
        check("t1_tx_n2", 32'(tx), 1);
        check("t1_data_n2", 32'(tx_data), 32'h41);
        repeat (LT - 1) tick();
        check("t1_hold", 32'(grant), 1);
        tick();
        check("t1_release", 32'(grant), 0);

        // Interleave lock: two simultaneous lines never mix.
        do_reset();
        expect_byte(8'h41, 2'b01); expect_byte(8'h42, 2'b01); expect_byte(8'h0A, 2'b01);
        expect_byte(8'h78, 2'b10); expect_byte(8'h79, 2'b10); expect_byte(8'h0A, 2'b10);
        wr(2'b11, 8'h41, 8'h78);
        wr(2'b11, 8'h42, 8'h79);
        wr(2'b11, 8'h0A, 8'h0A);
        drain("t2_drain", 60);
        tick();
        check("t2_idle", 32'(grant), 0);

        // Backpressure mid-line longer than the timeout; CR passes through unchanged.
        expect_byte(8'h50, 2'b01);
        wr(2'b01, 8'h50, 8'h00);
        tick();
        tx_full = 1'b1;
        expect_byte(8'h51, 2'b01); expect_byte(8'h0D, 2'b01);
        expect_byte(8'h53, 2'b01); expect_byte(8'h0A, 2'b01);
        wr(2'b01, 8'h51, 8'h00);
        wr(2'b01, 8'h0D, 8'h00);
        wr(2'b01, 8'h53, 8'h00);
        wr(2'b01, 8'h0A, 8'h00);
        repeat (LT + 6) tick();
        check("t3_grant_held", 32'(grant), 1);
        check("t3_no_tx", 32'(tx), 0);
        check("t3_full", 32'(req_full), 1);
        tx_full = 1'b0;
        nb = sb.size();
        for (int i = 0; i < nb; i++) begin
            tick();
            check("t3_burst", 32'(tx), 1);
        end
        tick();
        check("t3_release", 32'(grant), 0);
        check("t3_sb", 32'(sb.size()), 0);

        // Overflow with the UART stalled; only the first DEPTH bytes go out.
        tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_byte(8'(8'h61 + i), 2'b10);
            wr(2'b10, 8'h00, 8'(8'h61 + i));
        end
        check("t4_full", 32'(req_full), 2);
        check("t4_ovf_none", 32'(ovf), 0);
        wr(2'b10, 8'h00, 8'h65);
        check("t4_ovf_set", 32'(ovf), 2);
        ovf_clr = 1'b1;
        wr(2'b10, 8'h00, 8'h66);
        ovf_clr = 1'b0;
        check("t4_clr_priority", 32'(ovf), 0);
        wr(2'b10, 8'h00, 8'h67);
        check("t4_ovf_again", 32'(ovf), 2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", 32'(ovf), 0);
        tx_full = 1'b0;
        drain("t4_drain", 20);
        for (int i = 0; i < int'(LT) + 10 && grant != 2'b00; i++) tick();
        check("t4_timeout", 32'(grant), 0);
        check("t4_full_clear", 32'(req_full), 0);

        // Fairness: one-byte LF lines from both requesters alternate owners.
        tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_byte(8'h0A, 2'b01);
            expect_byte(8'h0A, 2'b10);
        end
        for (int i = 0; i < 3; i++) wr(2'b11, 8'h0A, 8'h0A);
        tx_full = 1'b0;
        drain("t5_drain", 60);
        tick();
        check("t5_idle", 32'(grant), 0);

        // Reset mid-line clears outputs at once and discards queued bytes.
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) wr(2'b01, 8'(8'h31 + i), 8'h00);
        check("t6_ovf_pre", 32'(ovf), 1);
        check("t6_full_pre", 32'(req_full), 1);
        tx_full = 1'b0;
        tick();
        check("t6_tx_pre", 32'(tx), 1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx), 0);
        check("t6_rst_grant", 32'(grant), 0);
        check("t6_rst_full", 32'(req_full), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("t6_post_grant", 32'(grant), 0);
        check("t6_post_tx", 32'(tx), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
